spi_xfer_arbiter: RTL and testbench

Round-robin transaction scheduler that shares one `SPI_TOP` master among `N_REQ` requesters. It sequences each byte transfer end to end:
- arbitrate;
- program `SPCR_in`, `SPIBR_in`, `LSBFE` and `SPDR_From_user`;
- enable the master and wait for `SPIF`;
- return the received byte;
- enforce an inter-frame guard gap.

It sits between the user-side requesters and the `SPI_TOP` configuration/data ports.

---
 rtl/spi_xfer_arbiter_if.sv | 35 +++
 rtl/spi_xfer_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Bundle between the requester side, the transfer scheduler and the SPI_TOP config/data ports.
// The master modport is the scheduler's view of the bundle; the slave modport is the view of the surrounding requesters and SPI_TOP.
interface spi_xfer_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [8*N_REQ-1:0] req_br;
    logic [2*N_REQ-1:0] req_mode;
    logic [N_REQ-1:0]   req_lsbfe;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   err;
    logic [7:0]         rx_data;
    logic               busy;
    logic [7:0]         SPCR_in;
    logic [7:0]         SPIBR_in;
    logic               LSBFE;
    logic [7:0]         SPDR_From_user;
    logic               SS_master;
    logic               SPIF;
    logic [7:0]         SPDR_rx;

    modport master (
        input  req, req_data, req_br, req_mode, req_lsbfe, SPIF, SPDR_rx,
        output gnt, done, err, rx_data, busy,
        output SPCR_in, SPIBR_in, LSBFE, SPDR_From_user, SS_master
    );

    modport slave (
        output req, req_data, req_br, req_mode, req_lsbfe, SPIF, SPDR_rx,
        input  gnt, done, err, rx_data, busy,
        input  SPCR_in, SPIBR_in, LSBFE, SPDR_From_user, SS_master
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin scheduler sharing one SPI_TOP master: arbitrate, program, run one byte,
// return the received byte and hold SS high for a guard gap between frames.
module spi_xfer_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023,
    parameter int GUARD   = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_xfer_arbiter_if.master  bus
);
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int T_W     = $clog2(TIMEOUT + 1);
    localparam int G_W     = $clog2(GUARD + 1);
    localparam int TG_W    = (T_W > G_W) ? T_W : G_W;
    localparam int CNT_W   = (TG_W > 10) ? TG_W : 10;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD - 1);
    localparam logic [7:0]       SPCR_RESET  = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_DONE,
        S_GUARD
    } state_t;

    state_t             state_reg, state_next;
    logic [IW-1:0]      last_reg, last_next;
    logic [IW-1:0]      winner_reg, winner_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               spif_q_reg;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic [N_REQ-1:0]   err_reg, err_next;
    logic [7:0]         rx_data_reg, rx_data_next;
    logic               busy_reg, busy_next;
    logic [7:0]         spcr_reg, spcr_next;
    logic [7:0]         spibr_reg, spibr_next;
    logic               lsbfe_reg, lsbfe_next;
    logic [7:0]         spdr_reg, spdr_next;
    logic               ss_reg, ss_next;

    logic [7:0]         data_arr [N_REQ];
    logic [7:0]         br_arr   [N_REQ];
    logic [1:0]         mode_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = bus.req_data[8*gi +: 8];
            assign br_arr[gi]   = bus.req_br[8*gi +: 8];
            assign mode_arr[gi] = bus.req_mode[2*gi +: 2];
        end
    endgenerate

    // Scan from last+1 upward; descending loop lets the nearest requester win.
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          pick_valid;
    always_comb begin
        pick       = '0;
        idx        = '0;
        pick_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_reg) + k) % N_REQ);
            if (bus.req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    wire spif_rise = bus.SPIF & ~spif_q_reg;

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        winner_next  = winner_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        done_next    = '0;
        err_next     = '0;
        rx_data_next = rx_data_reg;
        spcr_next    = spcr_reg;
        spibr_next   = spibr_reg;
        lsbfe_next   = lsbfe_reg;
        spdr_next    = spdr_reg;
        ss_next      = ss_reg;

        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_next     = pick;
                    last_next       = pick;
                    gnt_next        = '0;
                    gnt_next[pick]  = 1'b1;
                    // Configuration lands a cycle ahead of SPE so SPI_TOP sees it stable.
                    spdr_next       = data_arr[pick];
                    spibr_next      = br_arr[pick];
                    lsbfe_next      = bus.req_lsbfe[pick];
                    spcr_next       = {4'b0001, mode_arr[pick], 2'b00};
                    ss_next         = 1'b0;
                    state_next      = S_SETUP;
                end
            end
            S_SETUP: begin
                spcr_next[6] = 1'b1;
                cnt_next     = '0;
                state_next   = S_XFER;
            end
            S_XFER: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (spif_rise) begin
                    rx_data_next          = bus.SPDR_rx;
                    done_next[winner_reg] = 1'b1;
                    spcr_next[6]          = 1'b0;
                    gnt_next              = '0;
                    state_next            = S_DONE;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    err_next[winner_reg]  = 1'b1;
                    spcr_next[6]          = 1'b0;
                    gnt_next              = '0;
                    state_next            = S_DONE;
                end
            end
            S_DONE: begin
                ss_next    = 1'b1;
                cnt_next   = '0;
                state_next = S_GUARD;
            end
            S_GUARD: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == GUARD_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg    <= IW'(N_REQ - 1);
            winner_reg  <= '0;
            cnt_reg     <= '0;
            spif_q_reg  <= 1'b0;
            gnt_reg     <= '0;
            done_reg    <= '0;
            err_reg     <= '0;
            rx_data_reg <= '0;
            busy_reg    <= 1'b0;
            spcr_reg    <= SPCR_RESET;
            spibr_reg   <= '0;
            lsbfe_reg   <= 1'b0;
            spdr_reg    <= '0;
            ss_reg      <= 1'b1;
        end else begin
            last_reg    <= last_next;
            winner_reg  <= winner_next;
            cnt_reg     <= cnt_next;
            spif_q_reg  <= bus.SPIF;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            rx_data_reg <= rx_data_next;
            busy_reg    <= busy_next;
            spcr_reg    <= spcr_next;
            spibr_reg   <= spibr_next;
            lsbfe_reg   <= lsbfe_next;
            spdr_reg    <= spdr_next;
            ss_reg      <= ss_next;
        end
    end

    assign bus.gnt            = gnt_reg;
    assign bus.done           = done_reg;
    assign bus.err            = err_reg;
    assign bus.rx_data        = rx_data_reg;
    assign bus.busy           = busy_reg;
    assign bus.SPCR_in        = spcr_reg;
    assign bus.SPIBR_in       = spibr_reg;
    assign bus.LSBFE          = lsbfe_reg;
    assign bus.SPDR_From_user = spdr_reg;
    assign bus.SS_master      = ss_reg;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: inputs driven and outputs sampled on the falling edge,
// one printed line per completed transfer.
module tb_spi_xfer_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.N_REQ(N)) bus();

    spi_xfer_arbiter #(
        .N_REQ  (N),
        .TIMEOUT(20),
        .GUARD  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        int         who;
        logic [7:0] rx;
        bit         is_err;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic set_req(input int i, input logic [7:0] d, input logic [7:0] br,
                           input logic [1:0] md, input logic lsb);
        bus.req_data[8*i +: 8] = d;
        bus.req_br[8*i +: 8]   = br;
        bus.req_mode[2*i +: 2] = md;
        bus.req_lsbfe[i]       = lsb;
    endtask

    task automatic wait_spe(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.SPCR_in[6] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err, bus.busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b busy=%b want all 0", bus.gnt, bus.done, bus.err, bus.busy);
        end
        n_cmp++;
        if (bus.SPCR_in !== 8'h10) begin
            n_bad++;
            $display("FAIL reset_spcr: got %h want 10", bus.SPCR_in);
        end
        n_cmp++;
        if (bus.SS_master !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ss: got %b want 1", bus.SS_master);
        end
        n_cmp++;
        if ({bus.rx_data, bus.SPIBR_in, bus.SPDR_From_user, bus.LSBFE} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_data: got rx=%h br=%h spdr=%h lsbfe=%b want 0", bus.rx_data, bus.SPIBR_in, bus.SPDR_From_user, bus.LSBFE);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok;
        set_req(0, 8'hAA, 8'd2, 2'b00, 1'b0);
        bus.req = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if ({bus.gnt, bus.SS_master, bus.SPCR_in} !== {4'b0001, 1'b0, 8'h10}) begin
            n_bad++;
            $display("FAIL single_setup: got gnt=%b ss=%b spcr=%h want 0001 0 10", bus.gnt, bus.SS_master, bus.SPCR_in);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.SPCR_in, bus.SPDR_From_user, bus.SPIBR_in, bus.SS_master} !== {8'h50, 8'hAA, 8'h02, 1'b0}) begin
            n_bad++;
            $display("FAIL single_xfer: got spcr=%h spdr=%h br=%h ss=%b want 50 aa 02 0", bus.SPCR_in, bus.SPDR_From_user, bus.SPIBR_in, bus.SS_master);
        end
        bus.req = 4'b0000;
        sb.push_back('{who: 0, rx: 8'h3C, is_err: 1'b0});
        @(negedge clk);
        bus.SPDR_rx = 8'h3C;
        bus.SPIF    = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        $display("xfer: req%0d done=%b err=%b rx=%h", e.who, bus.done, bus.err, bus.rx_data);
        n_cmp++;
        if ({bus.done, bus.err, bus.rx_data, bus.gnt} !== {4'(1 << e.who), 4'b0000, e.rx, 4'b0000}) begin
            n_bad++;
            $display("FAIL single_done: got done=%b err=%b rx=%h gnt=%b want %b 0000 %h 0000", bus.done, bus.err, bus.rx_data, bus.gnt, 4'(1 << e.who), e.rx);
        end
        last_rx  = e.rx;
        bus.SPIF = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.SS_master, bus.done, bus.busy} !== {1'b1, 4'b0000, 1'b1}) begin
                n_bad++;
                $display("FAIL single_guard%0d: got ss=%b done=%b busy=%b want 1 0000 1", g, bus.SS_master, bus.done, bus.busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: got busy=%b want 0", bus.busy);
        end
        wait_idle(10, ok);
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        int   last;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'hA0 + 8'(i), 8'd1, 2'b00, 1'b0);
        bus.req = 4'b1111;
        last = N - 1;
        for (int t = 0; t < 5; t++) begin
            last = (last + 1) % N;
            sb.push_back('{who: last, rx: 8'h10 + 8'(t), is_err: 1'b0});
        end
        for (int t = 0; t < 5; t++) begin
            wait_spe(40, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rr_spe%0d: got no SPE within 40 cycles want SPE", t);
            end
            e = sb[0];
            n_cmp++;
            if ({bus.gnt, bus.SPDR_From_user} !== {4'(1 << e.who), 8'hA0 + 8'(e.who)}) begin
                n_bad++;
                $display("FAIL rr_gnt%0d: got gnt=%b spdr=%h want %b %h", t, bus.gnt, bus.SPDR_From_user, 4'(1 << e.who), 8'hA0 + 8'(e.who));
            end
            bus.SPDR_rx = e.rx;
            bus.SPIF    = 1'b1;
            @(negedge clk);
            e = sb.pop_front();
            $display("xfer: req%0d done=%b err=%b rx=%h", e.who, bus.done, bus.err, bus.rx_data);
            n_cmp++;
            if ({bus.done, bus.err, bus.rx_data} !== {4'(1 << e.who), 4'b0000, e.rx}) begin
                n_bad++;
                $display("FAIL rr_done%0d: got done=%b err=%b rx=%h want %b 0000 %h", t, bus.done, bus.err, bus.rx_data, 4'(1 << e.who), e.rx);
            end
            last_rx  = e.rx;
            bus.SPIF = 1'b0;
        end
        bus.req = 4'b0000;
        wait_idle(20, ok);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   cyc;
        set_req(1, 8'h11, 8'd3, 2'b01, 1'b0);
        bus.req = 4'b0010;
        wait_spe(20, ok);
        sb.push_back('{who: 1, rx: last_rx, is_err: 1'b1});
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if ((bus.err | bus.done) !== 4'b0000) break;
        end
        bus.req = 4'b0000;
        e = sb.pop_front();
        $display("xfer: req%0d done=%b err=%b rx=%h", e.who, bus.done, bus.err, bus.rx_data);
        n_cmp++;
        if (cyc !== 21) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles want 21", cyc);
        end
        n_cmp++;
        if ({bus.err, bus.done, bus.rx_data} !== {4'(1 << e.who), 4'b0000, e.rx}) begin
            n_bad++;
            $display("FAIL timeout_err: got err=%b done=%b rx=%h want %b 0000 %h", bus.err, bus.done, bus.rx_data, 4'(1 << e.who), e.rx);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bit   ok;
        set_req(2, 8'h33, 8'd4, 2'b00, 1'b0);
        bus.req = 4'b0100;
        wait_spe(20, ok);
        repeat (20) @(negedge clk);
        bus.SPDR_rx = 8'hC3;
        bus.SPIF    = 1'b1;
        sb.push_back('{who: 2, rx: 8'hC3, is_err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        $display("xfer: req%0d done=%b err=%b rx=%h", e.who, bus.done, bus.err, bus.rx_data);
        n_cmp++;
        if ({bus.done, bus.err, bus.rx_data} !== {4'(1 << e.who), 4'b0000, e.rx}) begin
            n_bad++;
            $display("FAIL simul_done: got done=%b err=%b rx=%h want %b 0000 %h", bus.done, bus.err, bus.rx_data, 4'(1 << e.who), e.rx);
        end
        last_rx  = e.rx;
        bus.SPIF = 1'b0;
        bus.req  = 4'b0000;
        wait_idle(20, ok);
    endtask

    task automatic test_mode_lsbfe();
        exp_t e;
        bit   ok;
        logic [3:0] seen;
        bus.SPIF = 1'b1;
        set_req(2, 8'h5A, 8'h07, 2'b11, 1'b1);
        bus.req = 4'b0100;
        wait_spe(20, ok);
        n_cmp++;
        if ({bus.SPCR_in, bus.LSBFE, bus.SPIBR_in, bus.SPDR_From_user} !== {8'h5C, 1'b1, 8'h07, 8'h5A}) begin
            n_bad++;
            $display("FAIL mode_cfg: got spcr=%h lsbfe=%b br=%h spdr=%h want 5c 1 07 5a", bus.SPCR_in, bus.LSBFE, bus.SPIBR_in, bus.SPDR_From_user);
        end
        seen = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.done | bus.err;
        end
        n_cmp++;
        if (seen !== 4'b0000) begin
            n_bad++;
            $display("FAIL mode_spif_held: got done|err=%b want 0000", seen);
        end
        bus.SPIF = 1'b0;
        @(negedge clk);
        bus.SPDR_rx = 8'hE7;
        bus.SPIF    = 1'b1;
        sb.push_back('{who: 2, rx: 8'hE7, is_err: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        $display("xfer: req%0d done=%b err=%b rx=%h", e.who, bus.done, bus.err, bus.rx_data);
        n_cmp++;
        if ({bus.done, bus.err, bus.rx_data} !== {4'(1 << e.who), 4'b0000, e.rx}) begin
            n_bad++;
            $display("FAIL mode_done: got done=%b err=%b rx=%h want %b 0000 %h", bus.done, bus.err, bus.rx_data, 4'(1 << e.who), e.rx);
        end
        last_rx  = e.rx;
        bus.SPIF = 1'b0;
        bus.req  = 4'b0000;
        wait_idle(20, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.req = 4'b0100;
        wait_spe(20, ok);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.SPCR_in, bus.SS_master, bus.gnt, bus.busy} !== {8'h10, 1'b1, 4'b0000, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid: got spcr=%h ss=%b gnt=%b busy=%b want 10 1 0000 0", bus.SPCR_in, bus.SS_master, bus.gnt, bus.busy);
        end
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_first_winner: got gnt=%b want 0001", bus.gnt);
        end
        bus.req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_br    = '0;
        bus.req_mode  = '0;
        bus.req_lsbfe = '0;
        bus.SPIF      = 1'b0;
        bus.SPDR_rx   = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_mode_lsbfe();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
